// File: rtl/rom_counter_pkg.sv
// Shared types and elaboration-time table builders for the ROM-driven step counter.
// Tables are sized for the widest legal counter; each instance uses only its low entries.
package rom_counter_pkg;

  localparam int unsigned MODE_WRAP = 0;
  localparam int unsigned MODE_SAT  = 1;

  localparam int unsigned RomWidthMax = 8;
  localparam int unsigned RomDepthMax = 256;

  typedef enum logic {
    DIR_DOWN = 1'b0,
    DIR_UP   = 1'b1
  } dir_e;

  typedef logic [RomDepthMax-1:0][RomWidthMax-1:0] rom_t;
  typedef logic [RomDepthMax-1:0]                  limit_rom_t;

  // Next count for one step from c; 32-bit arithmetic so c+STEP never overflows.
  function automatic int unsigned next_val(int unsigned c, int unsigned step,
                                           int unsigned max_val, int unsigned sat,
                                           dir_e dir);
    if (dir == DIR_UP) begin
      if (c + step <= max_val) return c + step;
      return (sat == MODE_SAT) ? max_val : c + step - (max_val + 1);
    end
    if (c >= step) return c - step;
    return (sat == MODE_SAT) ? 0 : c + max_val + 1 - step;
  endfunction

  // With 1 <= STEP <= MAX_VAL a wrap and a clamp happen on exactly the same steps.
  function automatic logic step_limits(int unsigned c, int unsigned step,
                                       int unsigned max_val, dir_e dir);
    if (dir == DIR_UP) return (c + step > max_val);
    return (c < step);
  endfunction

  function automatic rom_t build_rom(int unsigned width, int unsigned step,
                                     int unsigned max_val, int unsigned sat, dir_e dir);
    rom_t        rom;
    int unsigned depth;
    rom   = '0;
    depth = 32'd1 << width;
    for (int unsigned c = 0; c < depth; c++) begin
      if (c <= max_val) begin
        rom[c[7:0]] = 8'(next_val(c, step, max_val, sat, dir));
      end
    end
    return rom;
  endfunction

  function automatic limit_rom_t build_limit_rom(int unsigned width, int unsigned step,
                                                 int unsigned max_val, dir_e dir);
    limit_rom_t  rom;
    int unsigned depth;
    rom   = '0;
    depth = 32'd1 << width;
    for (int unsigned c = 0; c < depth; c++) begin
      if (c <= max_val) begin
        rom[c[7:0]] = step_limits(c, step, max_val, dir);
      end
    end
    return rom;
  endfunction

endpackage

// File: rtl/step_rom.sv
// Constant lookup table giving the next count and the wrap/clamp flag for one direction.
// Addresses above MAX_VAL read back 0 so a corrupted count recovers to a legal value.
module step_rom
  import rom_counter_pkg::*;
#(
  parameter int unsigned WIDTH    = 4,
  parameter int unsigned STEP     = 1,
  parameter int unsigned MAX_VAL  = 15,
  parameter int unsigned SATURATE = MODE_WRAP,
  parameter dir_e        DIR      = DIR_UP
) (
  input  logic [WIDTH-1:0] addr_i,
  output logic [WIDTH-1:0] data_o,
  output logic             limit_o
);

  localparam rom_t       Rom      = build_rom(WIDTH, STEP, MAX_VAL, SATURATE, DIR);
  localparam limit_rom_t LimitRom = build_limit_rom(WIDTH, STEP, MAX_VAL, DIR);

  logic [RomWidthMax-1:0] addr_ext;

  assign addr_ext = RomWidthMax'(addr_i);
  assign data_o   = Rom[addr_ext][WIDTH-1:0];
  assign limit_o  = LimitRom[addr_ext];

endmodule

// File: rtl/rom_step_counter.sv
// Registered up/down counter whose next values come from two constant step ROMs.
// Priority per edge: load, then en, then hold; limit pulses for one cycle on a wrap/clamp.
module rom_step_counter
  import rom_counter_pkg::*;
#(
  parameter int unsigned WIDTH    = 4,
  parameter int unsigned STEP     = 1,
  parameter int unsigned MAX_VAL  = (1 << WIDTH) - 1,
  parameter int unsigned SATURATE = MODE_WRAP
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             limit,
  output logic             at_max,
  output logic             at_min
);

  if (WIDTH < 2 || WIDTH > 8) begin : g_bad_width
    $error("rom_step_counter: WIDTH must be 2..8");
  end
  if (MAX_VAL < 1 || MAX_VAL > (1 << WIDTH) - 1) begin : g_bad_max
    $error("rom_step_counter: MAX_VAL must fit in WIDTH bits");
  end
  if (STEP < 1 || STEP > MAX_VAL) begin : g_bad_step
    $error("rom_step_counter: STEP must be 1..MAX_VAL");
  end

  localparam logic [WIDTH-1:0] MaxVal = WIDTH'(MAX_VAL);

  logic [WIDTH-1:0] count_q, count_d;
  logic             limit_q, limit_d;
  logic [WIDTH-1:0] inc_data, dec_data, load_clamped;
  logic             inc_limit, dec_limit;

  step_rom #(
    .WIDTH   (WIDTH),
    .STEP    (STEP),
    .MAX_VAL (MAX_VAL),
    .SATURATE(SATURATE),
    .DIR     (DIR_UP)
  ) u_inc_rom (
    .addr_i (count_q),
    .data_o (inc_data),
    .limit_o(inc_limit)
  );

  step_rom #(
    .WIDTH   (WIDTH),
    .STEP    (STEP),
    .MAX_VAL (MAX_VAL),
    .SATURATE(SATURATE),
    .DIR     (DIR_DOWN)
  ) u_dec_rom (
    .addr_i (count_q),
    .data_o (dec_data),
    .limit_o(dec_limit)
  );

  assign load_clamped = (load_val > MaxVal) ? MaxVal : load_val;

  always_comb begin
    count_d = count_q;
    limit_d = 1'b0;
    if (load) begin
      count_d = load_clamped;
    end else if (en) begin
      if (up) begin
        count_d = inc_data;
        limit_d = inc_limit;
      end else begin
        count_d = dec_data;
        limit_d = dec_limit;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
      limit_q <= 1'b0;
    end else begin
      count_q <= count_d;
      limit_q <= limit_d;
    end
  end

  assign count  = count_q;
  assign limit  = limit_q;
  assign at_max = (count_q == MaxVal);
  assign at_min = (count_q == '0);

endmodule
